// File: rtl/alu_rs_pkg.sv
// Shared ALU opcode encoding and default tag width for the ALU reservation station.
package alu_rs_pkg;

    localparam int ROB_WIDTH_DEF = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_XOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLL  = 4'd8,
        OP_LT   = 4'd9,
        OP_LTU  = 4'd10,
        OP_EQ   = 4'd11,
        OP_NE   = 4'd12,
        OP_GE   = 4'd13,
        OP_GEU  = 4'd14,
        OP_JALR = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_rs_select.sv
// Combinational issue picker: lowest-index candidate, or lowest age rank with ALU_RS_AGE_ORDER_EN.
// Zero latency; no flow control of its own.
module rs_select #(
    parameter int RS_WIDTH = 3
) (
    input  logic [(1<<RS_WIDTH)-1:0]                cand,
`ifdef ALU_RS_AGE_ORDER_EN
    input  logic [(1<<RS_WIDTH)-1:0][RS_WIDTH-1:0]  rank,
`endif
    output logic                                    found,
    output logic [RS_WIDTH-1:0]                     idx
);
    localparam int RS_SIZE = 1 << RS_WIDTH;

`ifdef ALU_RS_AGE_ORDER_EN
    logic [RS_WIDTH-1:0] best;

    // Ranks of busy entries are unique, so a strict compare finds the single oldest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cand[i] && (!found || rank[i] < best)) begin
                found = 1'b1;
                idx   = i[RS_WIDTH-1:0];
                best  = rank[i];
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                idx   = i[RS_WIDTH-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: issue 1 edge after an entry becomes ready; rs_full stalls dispatch, rdy_in low freezes all.
// ALU_RS_AGE_ORDER_EN switches selection from lowest-index to oldest-first.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int RS_WIDTH  = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 inst_signal,
    input  logic [3:0]           inst_opcode,
    input  logic [31:0]          inst_vj,
    input  logic [31:0]          inst_vk,
    input  logic [ROB_WIDTH-1:0] inst_qj,
    input  logic [ROB_WIDTH-1:0] inst_qk,
    input  logic                 inst_rj,
    input  logic                 inst_rk,
    input  logic [ROB_WIDTH-1:0] inst_tag,
    output logic                 rs_full,
    input  logic                 alu_done,
    input  logic [31:0]          alu_value,
    input  logic [ROB_WIDTH-1:0] alu_tag,
    input  logic                 lsb_done,
    input  logic [31:0]          lsb_value,
    input  logic [ROB_WIDTH-1:0] lsb_tag,
    output logic                 cal_signal,
    output logic [3:0]           opcode,
    output logic [31:0]          lhs,
    output logic [31:0]          rhs,
    output logic [ROB_WIDTH-1:0] tag
);
    localparam int RS_SIZE = 1 << RS_WIDTH;

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   rj;
    logic [RS_SIZE-1:0]   rk;
    logic [3:0]           op_q   [RS_SIZE];
    logic [31:0]          vj_q   [RS_SIZE];
    logic [31:0]          vk_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] dest_q [RS_SIZE];

    logic [RS_SIZE-1:0]   cand;
    logic                 sel_found;
    logic [RS_WIDTH-1:0]  sel_idx;
    logic [RS_WIDTH-1:0]  free_idx;
    logic                 do_insert;
    logic                 ins_rj;
    logic                 ins_rk;
    logic [31:0]          ins_vj;
    logic [31:0]          ins_vk;

`ifdef ALU_RS_AGE_ORDER_EN
    localparam logic [RS_WIDTH-1:0] RANK_ONE = {{(RS_WIDTH-1){1'b0}}, 1'b1};
    logic [RS_SIZE-1:0][RS_WIDTH-1:0] rank;
    logic [RS_WIDTH-1:0]              busy_cnt;
    logic [RS_WIDTH-1:0]              new_rank;

    // Only meaningful when not full, so the wrap at RS_SIZE busy entries is harmless.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++)
            busy_cnt = busy_cnt + {{(RS_WIDTH-1){1'b0}}, busy[i]};
    end

    assign new_rank = busy_cnt - {{(RS_WIDTH-1){1'b0}}, sel_found};
`endif

    assign rs_full   = &busy;
    assign cand      = busy & rj & rk;
    assign do_insert = inst_signal & ~rs_full;

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy[i])
                free_idx = i[RS_WIDTH-1:0];
    end

    // Resolve incoming operands against this cycle's broadcasts so no wakeup slips past the insert.
    always_comb begin
        ins_rj = inst_rj;
        ins_vj = inst_vj;
        ins_rk = inst_rk;
        ins_vk = inst_vk;
        if (!inst_rj) begin
            if (alu_done && inst_qj == alu_tag) begin
                ins_rj = 1'b1;
                ins_vj = alu_value;
            end else if (lsb_done && inst_qj == lsb_tag) begin
                ins_rj = 1'b1;
                ins_vj = lsb_value;
            end
        end
        if (!inst_rk) begin
            if (alu_done && inst_qk == alu_tag) begin
                ins_rk = 1'b1;
                ins_vk = alu_value;
            end else if (lsb_done && inst_qk == lsb_tag) begin
                ins_rk = 1'b1;
                ins_vk = lsb_value;
            end
        end
    end

    rs_select #(
        .RS_WIDTH (RS_WIDTH)
    ) u_select (
        .cand  (cand),
`ifdef ALU_RS_AGE_ORDER_EN
        .rank  (rank),
`endif
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy       <= '0;
            cal_signal <= 1'b0;
            opcode     <= OP_NOP;
            lhs        <= '0;
            rhs        <= '0;
            tag        <= '0;
        end else if (rdy_in && clear_signal) begin
            busy       <= '0;
            cal_signal <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rj[i]) begin
                    if (alu_done && qj_q[i] == alu_tag) begin
                        rj[i]   <= 1'b1;
                        vj_q[i] <= alu_value;
                    end else if (lsb_done && qj_q[i] == lsb_tag) begin
                        rj[i]   <= 1'b1;
                        vj_q[i] <= lsb_value;
                    end
                end
                if (busy[i] && !rk[i]) begin
                    if (alu_done && qk_q[i] == alu_tag) begin
                        rk[i]   <= 1'b1;
                        vk_q[i] <= alu_value;
                    end else if (lsb_done && qk_q[i] == lsb_tag) begin
                        rk[i]   <= 1'b1;
                        vk_q[i] <= lsb_value;
                    end
                end
`ifdef ALU_RS_AGE_ORDER_EN
                if (sel_found && busy[i] && rank[i] > rank[sel_idx])
                    rank[i] <= rank[i] - RANK_ONE;
`endif
            end

            cal_signal <= sel_found;
            if (sel_found) begin
                busy[sel_idx] <= 1'b0;
                opcode        <= op_q[sel_idx];
                lhs           <= vj_q[sel_idx];
                rhs           <= vk_q[sel_idx];
                tag           <= dest_q[sel_idx];
            end

            // free_idx was free at the start of the cycle, so it never aliases sel_idx.
            if (do_insert) begin
                busy[free_idx]   <= 1'b1;
                op_q[free_idx]   <= inst_opcode;
                vj_q[free_idx]   <= ins_vj;
                vk_q[free_idx]   <= ins_vk;
                qj_q[free_idx]   <= inst_qj;
                qk_q[free_idx]   <= inst_qk;
                rj[free_idx]     <= ins_rj;
                rk[free_idx]     <= ins_rk;
                dest_q[free_idx] <= inst_tag;
`ifdef ALU_RS_AGE_ORDER_EN
                rank[free_idx]   <= new_rank;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a queue-based reference model predicts every issue, a negedge monitor compares.
module tb_alu_rs;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_signal, inst_signal;
    logic [3:0]  inst_opcode;
    logic [31:0] inst_vj, inst_vk;
    logic [3:0]  inst_qj, inst_qk, inst_tag;
    logic        inst_rj, inst_rk;
    logic        rs_full;
    logic        alu_done, lsb_done;
    logic [31:0] alu_value, lsb_value;
    logic [3:0]  alu_tag, lsb_tag;
    logic        cal_signal;
    logic [3:0]  opcode;
    logic [31:0] lhs, rhs;
    logic [3:0]  tag;

    always #5 clk_in = ~clk_in;

    alu_rs #(.ROB_WIDTH(4), .RS_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .inst_signal(inst_signal), .inst_opcode(inst_opcode),
        .inst_vj(inst_vj), .inst_vk(inst_vk), .inst_qj(inst_qj), .inst_qk(inst_qk),
        .inst_rj(inst_rj), .inst_rk(inst_rk), .inst_tag(inst_tag), .rs_full(rs_full),
        .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
    );

    typedef struct {
        int          slot;
        logic [3:0]  op;
        logic [31:0] vj, vk;
        logic [3:0]  qj, qk;
        bit          rj, rk;
        logic [3:0]  dest;
    } ent_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [3:0]  t;
    } iss_t;

    ent_t rs_q[$];
    iss_t exp_q[$];
    bit   exp_cal = 1'b0;
    bit   fresh   = 1'b0;
    bit   mon_en  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic ent_t wake(input ent_t e);
        if (!e.rj) begin
            if (alu_done && e.qj == alu_tag) begin e.rj = 1; e.vj = alu_value; end
            else if (lsb_done && e.qj == lsb_tag) begin e.rj = 1; e.vj = lsb_value; end
        end
        if (!e.rk) begin
            if (alu_done && e.qk == alu_tag) begin e.rk = 1; e.vk = alu_value; end
            else if (lsb_done && e.qk == lsb_tag) begin e.rk = 1; e.vk = lsb_value; end
        end
        return e;
    endfunction

    // Reference model: entries kept in arrival order, each remembers the slot it occupies.
    always @(posedge clk_in) begin
        int   pick;
        int   n;
        bit   used [8];
        ent_t e;
        iss_t x;
        fresh = 1'b0;
        if (rst_in) begin
            rs_q.delete();
            exp_q.delete();
            exp_cal = 1'b0;
        end else if (rdy_in) begin
            fresh = 1'b1;
            if (clear_signal) begin
                rs_q.delete();
                exp_cal = 1'b0;
            end else begin
                pick = -1;
                for (int s = 0; s < 8; s++) used[s] = 1'b0;
                for (int k = 0; k < rs_q.size(); k++) begin
                    used[rs_q[k].slot] = 1'b1;
                    if (rs_q[k].rj && rs_q[k].rk) begin
`ifdef ALU_RS_AGE_ORDER_EN
                        if (pick < 0) pick = k;
`else
                        if (pick < 0 || rs_q[k].slot < rs_q[pick].slot) pick = k;
`endif
                    end
                end
                n = rs_q.size();
                for (int k = 0; k < rs_q.size(); k++) rs_q[k] = wake(rs_q[k]);
                if (pick >= 0) begin
                    x.op = rs_q[pick].op; x.a = rs_q[pick].vj;
                    x.b  = rs_q[pick].vk; x.t = rs_q[pick].dest;
                    exp_q.push_back(x);
                    rs_q.delete(pick);
                    exp_cal = 1'b1;
                end else begin
                    exp_cal = 1'b0;
                end
                if (inst_signal && n < 8) begin
                    e.slot = 0;
                    for (int s = 7; s >= 0; s--) if (!used[s]) e.slot = s;
                    e.op = inst_opcode; e.dest = inst_tag;
                    e.rj = inst_rj; e.vj = inst_vj; e.qj = inst_qj;
                    e.rk = inst_rk; e.vk = inst_vk; e.qk = inst_qk;
                    rs_q.push_back(wake(e));
                end
            end
        end
    end

    always @(negedge clk_in) begin
        iss_t x;
        if (mon_en) begin
            chk("cal_signal", {31'd0, cal_signal}, {31'd0, exp_cal});
            chk("rs_full", {31'd0, rs_full}, (rs_q.size() == 8) ? 32'd1 : 32'd0);
            if (fresh && cal_signal) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected actual tag=%0h required no issue", tag);
                end else begin
                    x = exp_q.pop_front();
                    chk("issue_opcode", {28'd0, opcode}, {28'd0, x.op});
                    chk("issue_lhs", lhs, x.a);
                    chk("issue_rhs", rhs, x.b);
                    chk("issue_tag", {28'd0, tag}, {28'd0, x.t});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        inst_signal  = 1'b0;
        alu_done     = 1'b0;
        lsb_done     = 1'b0;
        clear_signal = 1'b0;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic rj_i, input logic [31:0] vj_i,
                            input logic [3:0] qj_i, input logic rk_i, input logic [31:0] vk_i,
                            input logic [3:0] qk_i, input logic [3:0] dest);
        inst_signal = 1'b1; inst_opcode = op; inst_tag = dest;
        inst_rj = rj_i; inst_vj = vj_i; inst_qj = qj_i;
        inst_rk = rk_i; inst_vk = vk_i; inst_qk = qk_i;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; inst_signal = 1'b0;
        inst_opcode = '0; inst_vj = '0; inst_vk = '0; inst_qj = '0; inst_qk = '0;
        inst_rj = 1'b0; inst_rk = 1'b0; inst_tag = '0;
        alu_done = 1'b0; alu_value = '0; alu_tag = '0;
        lsb_done = 1'b0; lsb_value = '0; lsb_tag = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("reset_cal", {31'd0, cal_signal}, 32'd0);
        chk("reset_opcode", {28'd0, opcode}, 32'd0);
        chk("reset_lhs", lhs, 32'd0);
        chk("reset_rhs", rhs, 32'd0);
        chk("reset_tag", {28'd0, tag}, 32'd0);
        chk("reset_full", {31'd0, rs_full}, 32'd0);
        mon_en = 1'b1;

        // Ready ADD issues two edges after dispatch.
        dispatch(4'd4, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        step();
        chk("add_not_early", {31'd0, cal_signal}, 32'd0);
        step();
        chk("add_cal", {31'd0, cal_signal}, 32'd1);
        chk("add_opcode", {28'd0, opcode}, 32'd4);
        chk("add_lhs", lhs, 32'd5);
        chk("add_rhs", rhs, 32'd7);
        chk("add_tag", {28'd0, tag}, 32'd3);
        step();
        chk("add_cal_drop", {31'd0, cal_signal}, 32'd0);

        // Wakeup through the ALU bus.
        dispatch(4'd5, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 4'd4);
        step();
        alu_done = 1'b1; alu_tag = 4'd2; alu_value = 32'd10;
        step();
        chk("sub_not_early", {31'd0, cal_signal}, 32'd0);
        step();
        chk("sub_cal", {31'd0, cal_signal}, 32'd1);
        chk("sub_lhs", lhs, 32'd10);
        chk("sub_rhs", rhs, 32'd1);
        step();

        // Operand captured from the LSB bus in the dispatch cycle.
        dispatch(4'd2, 1'b1, 32'h55, 4'd0, 1'b0, 32'd0, 4'd6, 4'd5);
        lsb_done = 1'b1; lsb_tag = 4'd6; lsb_value = 32'hFFFF_FFFF;
        step();
        step();
        chk("bypass_cal", {31'd0, cal_signal}, 32'd1);
        chk("bypass_rhs", rhs, 32'hFFFF_FFFF);
        step();

        // Fill, overflow dispatch, then drain one per cycle.
        for (int i = 0; i < 8; i++) begin
            dispatch(4'd3, 1'b0, 32'd0, 4'(i), 1'b1, 32'(i * 3), 4'd0, 4'(i));
            step();
        end
        chk("fill_full", {31'd0, rs_full}, 32'd1);
        dispatch(4'd4, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd9);
        step();
        chk("ninth_full", {31'd0, rs_full}, 32'd1);
        step();
        chk("ninth_ignored", {31'd0, cal_signal}, 32'd0);
        for (int p = 0; p < 4; p++) begin
            alu_done = 1'b1; alu_tag = 4'(2 * p);     alu_value = 32'h100 + 32'(p);
            lsb_done = 1'b1; lsb_tag = 4'(2 * p + 1); lsb_value = 32'h200 + 32'(p);
            step();
            if (p == 1) begin
                chk("drain_full_drop", {31'd0, rs_full}, 32'd0);
                chk("drain_cal", {31'd0, cal_signal}, 32'd1);
            end
        end
        repeat (8) step();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        // Flush with four waiting entries and an issue on the outputs.
        for (int i = 0; i < 4; i++) begin
            dispatch(4'd1, 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'd0, 4'd0, 4'(8 + i));
            step();
        end
        dispatch(4'd1, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0, 4'd13);
        step();
        step();
        chk("pre_clear_cal", {31'd0, cal_signal}, 32'd1);
        clear_signal = 1'b1;
        dispatch(4'd4, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd14);
        step();
        chk("clear_cal", {31'd0, cal_signal}, 32'd0);
        chk("clear_full", {31'd0, rs_full}, 32'd0);
        alu_done = 1'b1; alu_tag = 4'd8; lsb_done = 1'b1; lsb_tag = 4'd9;
        step();
        alu_done = 1'b1; alu_tag = 4'd10; lsb_done = 1'b1; lsb_tag = 4'd11;
        step();
        step();
        chk("clear_no_issue", {31'd0, cal_signal}, 32'd0);

        // Ordering: A waits in slot 1, B lands in slot 0, both become ready together.
        dispatch(4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd1);
        step();
        dispatch(4'd8, 1'b0, 32'd0, 4'd12, 1'b1, 32'd3, 4'd0, 4'd2);
        step();
        dispatch(4'd7, 1'b1, 32'd4, 4'd0, 1'b1, 32'd5, 4'd0, 4'd3);
        alu_done = 1'b1; alu_tag = 4'd12; alu_value = 32'd99;
        step();
        step();
`ifdef ALU_RS_AGE_ORDER_EN
        chk("order_first", {28'd0, tag}, 32'd2);
`else
        chk("order_first", {28'd0, tag}, 32'd3);
`endif
        rdy_in = 1'b0;
        repeat (3) step();
        chk("pause_cal_hold", {31'd0, cal_signal}, 32'd1);
`ifdef ALU_RS_AGE_ORDER_EN
        chk("pause_tag_hold", {28'd0, tag}, 32'd2);
`else
        chk("pause_tag_hold", {28'd0, tag}, 32'd3);
`endif
        rdy_in = 1'b1;
        step();
`ifdef ALU_RS_AGE_ORDER_EN
        chk("order_second", {28'd0, tag}, 32'd3);
`else
        chk("order_second", {28'd0, tag}, 32'd2);
`endif
        step();
        chk("order_done", {31'd0, cal_signal}, 32'd0);

        // Randomized traffic with pauses, flushes and colliding broadcasts.
        for (int c = 0; c < 800; c++) begin
            rdy_in       = ($urandom_range(0, 7) != 0);
            clear_signal = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 1)
                dispatch(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                         4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                         4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            alu_done  = ($urandom_range(0, 2) == 0);
            alu_tag   = 4'($urandom_range(0, 7));
            alu_value = $urandom;
            lsb_done  = ($urandom_range(0, 2) == 0);
            lsb_tag   = 4'($urandom_range(0, 7));
            lsb_value = $urandom;
            step();
        end
        rdy_in = 1'b1;
        step();
        clear_signal = 1'b1;
        step();
        repeat (3) step();
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
